// File: rtl/bb_pkg.sv
// Shared types and address helpers for the Blackbone RAM slave.
// The clear-engine state enum is only used when BB_RAM_CLEAR_EN is defined.
package bb_pkg;

  typedef enum logic {
    StClear,
    StReady
  } bb_state_e;

  // Number of word-index bits for an array of the given depth.
  function automatic int unsigned bb_idx_width(input int unsigned mem_words);
    return $clog2(mem_words);
  endfunction

  // Lowest address bit of the word index (bytes per word are ignored).
  function automatic int unsigned bb_idx_lsb(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

  // Highest address bit of the word index.
  function automatic int unsigned bb_idx_msb(input int unsigned mem_words,
                                             input int unsigned data_width);
    return bb_idx_lsb(data_width) + bb_idx_width(mem_words) - 1;
  endfunction

endpackage

// File: rtl/bb_ram_sp.sv
// Plain single-port word array: synchronous write, combinational read, no reset.
module bb_ram_sp #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 1024,
  localparam int unsigned IdxW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [IdxW-1:0]  idx_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] r_mem [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      r_mem[idx_i] <= wdata_i;
    end
  end

  assign rdata_o = r_mem[idx_i];

endmodule

// File: rtl/bb_ram_slave.sv
// Blackbone slave RAM endpoint with fixed one-cycle read latency.
// Define BB_RAM_CLEAR_EN to zero the array after reset before accepting traffic.
module bb_ram_slave
  import bb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_WORDS  = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH-1:0] s_addr_i,
  input  logic [DATA_WIDTH-1:0] s_din_i,
  input  logic                  s_en_i,
  input  logic                  s_we_i,
  output logic [DATA_WIDTH-1:0] s_dout_o,
  output logic                  ready_o,
  output logic                  drop_o
);

  localparam int unsigned IdxW   = bb_idx_width(MEM_WORDS);
  localparam int unsigned IdxLsb = bb_idx_lsb(DATA_WIDTH);
  localparam int unsigned IdxMsb = bb_idx_msb(MEM_WORDS, DATA_WIDTH);

  logic [IdxW-1:0]       w_bus_idx;
  logic                  w_bus_wr;
  logic                  w_ready;
  logic                  w_mem_we;
  logic [IdxW-1:0]       w_mem_idx;
  logic [DATA_WIDTH-1:0] w_mem_wdata;
  logic [DATA_WIDTH-1:0] w_mem_rdata;
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  w_unused_addr;

  // Byte-offset and upper address bits alias onto the same word.
  assign w_bus_idx     = s_addr_i[IdxMsb:IdxLsb];
  assign w_unused_addr = ^s_addr_i;
  assign w_bus_wr      = rst_i & s_en_i & s_we_i;

`ifdef BB_RAM_CLEAR_EN
  bb_state_e       r_state;
  bb_state_e       w_state_d;
  logic [IdxW-1:0] r_cnt;
  logic [IdxW-1:0] w_cnt_d;
  logic            r_drop;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state <= StClear;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
    end
  end

  // The clear engine owns the array port while clearing; bus writes are dropped.
  always_comb begin
    w_state_d   = r_state;
    w_cnt_d     = r_cnt;
    w_mem_we    = w_bus_wr;
    w_mem_idx   = w_bus_idx;
    w_mem_wdata = s_din_i;
    unique case (r_state)
      StClear: begin
        w_mem_we    = rst_i;
        w_mem_idx   = r_cnt;
        w_mem_wdata = '0;
        if (r_cnt == IdxW'(MEM_WORDS - 1)) begin
          w_state_d = StReady;
        end else begin
          w_cnt_d = r_cnt + IdxW'(1);
        end
      end
      StReady: begin
      end
      default: w_state_d = StClear;
    endcase
  end

  assign w_ready = (r_state == StReady);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_drop <= 1'b0;
    end else if (s_en_i && !w_ready) begin
      r_drop <= 1'b1;
    end
  end

  assign drop_o = r_drop;
`else
  assign w_mem_we    = w_bus_wr;
  assign w_mem_idx   = w_bus_idx;
  assign w_mem_wdata = s_din_i;
  assign w_ready     = 1'b1;
  assign drop_o      = 1'b0;
`endif

  bb_ram_sp #(
    .Width(DATA_WIDTH),
    .Depth(MEM_WORDS)
  ) u_ram (
    .clk_i  (clk_i),
    .we_i   (w_mem_we),
    .idx_i  (w_mem_idx),
    .wdata_i(w_mem_wdata),
    .rdata_o(w_mem_rdata)
  );

  // Reads while not ready return zero rather than array contents.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_dout <= '0;
    end else if (s_en_i && !s_we_i) begin
      r_dout <= w_ready ? w_mem_rdata : '0;
    end
  end

  assign s_dout_o = r_dout;
  assign ready_o  = w_ready;

endmodule

// File: tb/tb_bb_ram_slave.sv
// Scoreboard bench for bb_ram_slave (MEM_WORDS=16), follows BB_RAM_CLEAR_EN if defined.
module tb_bb_ram_slave;

  localparam int unsigned MW = 16;
`ifdef BB_RAM_CLEAR_EN
  localparam bit Clr = 1'b1;
`else
  localparam bit Clr = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [31:0] s_addr;
  logic [31:0] s_din;
  logic        s_en;
  logic        s_we;
  logic [31:0] s_dout;
  logic        ready;
  logic        drop;

  bb_ram_slave #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .MEM_WORDS (MW)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst_n),
    .s_addr_i(s_addr),
    .s_din_i (s_din),
    .s_en_i  (s_en),
    .s_we_i  (s_we),
    .s_dout_o(s_dout),
    .ready_o (ready),
    .drop_o  (drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference model state
  logic [31:0] model_mem [MW];
  logic [31:0] sb_q [$];
  int unsigned cyc = 0;
  bit          exp_ready;
  bit          exp_drop;
  bit          rd_flag;
  bit          rst_flag;
  logic [31:0] last_dout;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Model: sees each edge's inputs and predicts the bus response.
  always @(posedge clk) begin
    bit          rdy;
    int unsigned idx;
    rd_flag  = 1'b0;
    rst_flag = 1'b0;
    if (!rst_n) begin
      cyc      = 0;
      exp_drop = 1'b0;
      rst_flag = 1'b1;
      if (Clr) begin
        for (int i = 0; i < MW; i++) model_mem[i] = 32'h0;
      end
    end else begin
      rdy = Clr ? (cyc >= MW) : 1'b1;
      if (s_en) begin
        idx = (s_addr / 4) % MW;
        if (!rdy) exp_drop = 1'b1;
        if (s_we) begin
          if (rdy) model_mem[idx] = s_din;
        end else begin
          sb_q.push_back(rdy ? model_mem[idx] : 32'h0);
          rd_flag = 1'b1;
        end
      end
      if (cyc < MW) cyc++;
    end
    exp_ready = Clr ? (cyc >= MW) : 1'b1;
  end

  // Monitor: pops the scoreboard whenever a read was presented on the previous edge.
  always @(posedge clk) begin
    #1;
    if (rst_flag) begin
      last_dout = 32'h0;
    end else if (rd_flag) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_underflow @%0t: got read with empty queue, expected entry", $time);
      end else begin
        last_dout = sb_q.pop_front();
      end
    end
    chk("dout", s_dout, last_dout);
    chk("ready", {31'h0, ready}, {31'h0, exp_ready});
    chk("drop", {31'h0, drop}, {31'h0, exp_drop});
  end

  task automatic op(input bit en, input bit we, input logic [31:0] a, input logic [31:0] d);
    s_en   = en;
    s_we   = we;
    s_addr = a;
    s_din  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ops(input int n);
    for (int i = 0; i < n; i++) begin
      op(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), $urandom, $urandom);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    s_en   = 1'b0;
    s_we   = 1'b0;
    s_addr = '0;
    s_din  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    if (Clr) begin
      op(1'b1, 1'b0, 32'h8, 32'h0);
      op(1'b1, 1'b1, 32'h8, 32'h12345678);
      rand_ops(5);
      // Reset at clear count 7, then the full clear must repeat.
      rst_n = 1'b0;
      op(1'b0, 1'b0, 32'h0, 32'h0);
      op(1'b0, 1'b0, 32'h0, 32'h0);
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) op(1'b0, 1'b0, 32'h0, 32'h0);
      for (int i = 0; i < MW; i++) op(1'b1, 1'b0, 32'(i * 4), 32'h0);
      rst_n = 1'b0;
      op(1'b0, 1'b0, 32'h0, 32'h0);
      rst_n = 1'b1;
      rand_ops(24);
    end else begin
      for (int i = 0; i < MW; i++) op(1'b1, 1'b1, 32'(i * 4), $urandom);
      op(1'b1, 1'b1, 32'hC, 32'hA5A5A5A5);
      op(1'b1, 1'b0, 32'hC, 32'h0);
    end
    op(1'b1, 1'b1, 32'h4, 32'hDEADBEEF);
    op(1'b1, 1'b0, 32'h4, 32'h0);
    op(1'b1, 1'b1, 32'h0, 32'h11111111);
    op(1'b1, 1'b0, 32'h40, 32'h0);
    op(1'b1, 1'b0, 32'h43, 32'h0);
    op(1'b0, 1'b0, 32'h4, 32'h0);
    for (int i = 0; i < MW; i++) op(1'b1, 1'b0, 32'(i * 4 + 1), 32'h0);
    rand_ops(300);
    for (int i = 0; i < 3; i++) op(1'b0, 1'b0, 32'h0, 32'h0);
    chk("sb_drain", 32'(sb_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bb_ram_slave.md
# bb_ram_slave

Blackbone slave endpoint: single-port word memory answering one interconnect slave port (addr/din/en/we in, dout out). It is the responder at the far side of the Blackbone bus decoder and returns read data with fixed one-cycle latency, since the protocol has no stall or acknowledge. An optional post-reset clear engine zeroes the array before the slave accepts traffic.

## Interface
- ADDR_WIDTH, 32, bus address width in bits
- DATA_WIDTH, 32, bus data width; multiple of 8
- MEM_WORDS, 1024, array depth in DATA_WIDTH words; power of two, ≥2
- clk_i  in  1  bus clock; all logic on rising edge
- rst_i  in  1  reset, synchronous, active-low
- s_addr_i  in  ADDR_WIDTH  byte address from decoder
- s_din_i  in  DATA_WIDTH  write data
- s_en_i  in  1  access strobe, one access per asserted cycle
- s_we_i  in  1  1 = write, 0 = read; qualified by s_en_i
- s_dout_o  out  DATA_WIDTH  read data, registered
- ready_o  out  1  array initialised, accesses honoured
- drop_o  out  1  sticky: an access arrived while not ready

## Operation
- Word index = s_addr_i[log2(MEM_WORDS)+log2(DATA_WIDTH/8)-1 : log2(DATA_WIDTH/8)]; byte-offset bits and upper bits ignored (aliasing is legal, no error).
- Write (s_en_i & s_we_i & ready_o): mem[idx] <= s_din_i; s_dout_o holds its previous value.
- Read (s_en_i & ~s_we_i & ready_o): s_dout_o <= mem[idx] at next edge.
- s_en_i low: s_dout_o holds; no array access.
- FSM states: CLEAR, READY. Reset → CLEAR, clear counter = 0.
- CLEAR: each cycle mem[cnt] <= 0, cnt++; at cnt == MEM_WORDS-1 write last word, go READY next edge. Counter width log2(MEM_WORDS), no wrap past last word.
- Access during CLEAR: write discarded; read returns 0 next cycle; drop_o <= 1 in both cases.
- drop_o clears only on reset.
- Reset mid-CLEAR: counter restarts at 0, full clear repeats. Reset in READY: contents not guaranteed preserved with clear enabled (they are re-zeroed).

## Timing
- Reset values: s_dout_o = 0, drop_o = 0, ready_o = 0 (macro set) / 1 (macro unset).
- Read latency exactly 1 cycle; back-to-back reads every cycle, each returning its own address.
- Write then read same index on next cycle returns new data (write visible after its edge).
- CLEAR lasts exactly MEM_WORDS cycles after reset deasserts; ready_o rises on cycle MEM_WORDS.
- drop_o asserts the edge after the offending s_en_i cycle.

## Configuration
- BB_RAM_CLEAR_EN defined: CLEAR state and counter present, behaviour as above.
- Undefined: FSM and counter removed; ready_o = 1 from first cycle after reset; drop_o tied 0; array contents undefined until written.

## Structure
- Shared package bb_pkg: FSM state enum (CLEAR, READY), helper function for word-index bit range.
- One sub-module: bb_ram_sp — plain single-port synchronous array (we, idx, wdata, rdata), no reset; clear engine and bus logic stay in bb_ram_slave and drive its single port through a mux.

## Test plan
- Reset, MEM_WORDS=16, macro set → ready_o low 16 cycles, high on 16th; every read returns 0x00000000.
- Read during CLEAR at addr 0x8 → s_dout_o = 0 next cycle, drop_o = 1 and stays 1 until reset.
- Write 0xDEADBEEF to 0x4, read 0x4 next cycle → s_dout_o = 0xDEADBEEF one cycle after read.
- Write 0x11111111 to 0x0, read 0x40 (MEM_WORDS=16, aliases index 0) → 0x11111111.
- Reset asserted at clear count 7 → counter restarts, ready_o rises 16 cycles after release.
- Macro unset → ready_o = 1 first cycle post-reset; write 0xA5A5A5A5 @0xC then read → 0xA5A5A5A5; drop_o stays 0.
